// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//   Issue stage in front of the 8-bit ALU. Requests {opcode,a,b} are queued
//   in a DEPTH-entry FIFO. Illegal opcodes are removed when they reach the
//   head. The stage presents one legal operation at a time on registered
//   alu_* outputs and holds it until the result consumer accepts it.
//
// Optional feature:
//   `define ALU_ISSUE_DIVZERO_TRAP_EN  -> DIV (4'b0011) with b==0 is dropped
//                                        like an illegal opcode.
//   (undefined)                        -> such entries are issued unchanged.
//
// Ports:
//   clk         in   single clock, all state on posedge
//   rst_n       in   synchronous reset, active-low
//   flush       in   synchronous clear of FIFO and output stage
//   in_valid    in   request valid
//   in_ready    out  FIFO not full
//   in_opcode   in   [3:0] requested opcode
//   in_a, in_b  in   [7:0] operands
//   out_valid   out  alu_* hold a legal operation
//   out_ready   in   downstream consumed the ALU result this cycle
//   alu_opcode  out  [3:0] registered opcode
//   alu_a/b     out  [7:0] registered operands
//   level       out  FIFO occupancy (output register not counted)
//   drop_pulse  out  1-cycle pulse after a popped entry is discarded
//   drop_cnt    out  [7:0] saturating count of discarded entries
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_opcode,
    input  logic [7:0]                   in_a,
    input  logic [7:0]                   in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   alu_opcode,
    output logic [7:0]                   alu_a,
    output logic [7:0]                   alu_b,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         drop_pulse,
    output logic [7:0]                   drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    // Entry layout: {opcode[19:16], a[15:8], b[7:0]}
    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] count_reg;

    logic          out_valid_reg;
    logic [3:0]    alu_opcode_reg;
    logic [7:0]    alu_a_reg;
    logic [7:0]    alu_b_reg;
    logic          drop_pulse_reg;
    logic [7:0]    drop_cnt_reg;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [19:0]   head;
    logic          head_illegal;
    logic          load;
    logic          drop;

    assign full  = (count_reg == LW'(DEPTH));
    assign empty = (count_reg == '0);

    // No bypass: a push is refused whenever the FIFO is full, even if a pop
    // happens in the same cycle.
    assign push = in_valid && !full;
    assign pop  = !empty && (!out_valid_reg || out_ready);

    assign head = mem[rd_ptr_reg];

`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
    assign head_illegal = (head[19:16] >= 4'hA) ||
                          ((head[19:16] == 4'h3) && (head[7:0] == 8'h00));
`else
    assign head_illegal = (head[19:16] >= 4'hA);
`endif

    // A discarded head is still popped but never reaches the output register.
    assign load = pop && !head_illegal;
    assign drop = pop && head_illegal;

    // Storage array: no reset, written only on an accepted, non-flushed push.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem[wr_ptr_reg] <= {in_opcode, in_a, in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            out_valid_reg  <= 1'b0;
            alu_opcode_reg <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            drop_pulse_reg <= 1'b0;
            drop_cnt_reg   <= '0;
        end else if (flush) begin
            // drop_cnt and the (now invalid) alu_* values are kept.
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            out_valid_reg  <= 1'b0;
            drop_pulse_reg <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + LW'(1);
                2'b01:   count_reg <= count_reg - LW'(1);
                default: count_reg <= count_reg;
            endcase

            if (load) begin
                out_valid_reg  <= 1'b1;
                alu_opcode_reg <= head[19:16];
                alu_a_reg      <= head[15:8];
                alu_b_reg      <= head[7:0];
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg  <= 1'b0;
            end

            drop_pulse_reg <= drop;
            if (drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign in_ready   = !full;
    assign out_valid  = out_valid_reg;
    assign alu_opcode = alu_opcode_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign level      = count_reg;
    assign drop_pulse = drop_pulse_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule
